// File: rtl/vga_pixel_scanner.sv
// vga_pixel_scanner: 640x480@60 VGA timing, 8x8 store scan, palette output, optional CURSOR_OVERLAY_EN
module vga_pixel_scanner #(
  parameter logic [9:0] H_ACTIVE = 10'd640,
  parameter logic [9:0] H_FP     = 10'd16,
  parameter logic [9:0] H_SYNC   = 10'd96,
  parameter logic [9:0] H_BP     = 10'd48,
  parameter logic [9:0] V_ACTIVE = 10'd480,
  parameter logic [9:0] V_FP     = 10'd10,
  parameter logic [9:0] V_SYNC   = 10'd2,
  parameter logic [9:0] V_BP     = 10'd33,
  parameter logic [6:0] CELL_W   = 7'd80,
  parameter logic [5:0] CELL_H   = 6'd60,
  parameter logic [3:0] GRID_N   = 4'd8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] colorCode,
`ifdef CURSOR_OVERLAY_EN
  input  logic [7:0] curX,
  input  logic [7:0] curY,
`endif
  output logic [7:0] rx,
  output logic [7:0] ry,
  output logic       hsync,
  output logic       vsync,
  output logic       r,
  output logic       g,
  output logic       b,
  output logic       vblank,
  output logic       frameStart
);
  localparam logic [9:0] H_LAST = H_ACTIVE + H_FP + H_SYNC + H_BP - 10'd1;
  localparam logic [9:0] V_LAST = V_ACTIVE + V_FP + V_SYNC + V_BP - 10'd1;
  localparam logic [9:0] HS_LO  = H_ACTIVE + H_FP;
  localparam logic [9:0] HS_HI  = H_ACTIVE + H_FP + H_SYNC;
  localparam logic [9:0] VS_LO  = V_ACTIVE + V_FP;
  localparam logic [9:0] VS_HI  = V_ACTIVE + V_FP + V_SYNC;
  localparam logic [6:0] HSUB_LAST = CELL_W - 7'd1;
  localparam logic [5:0] VSUB_LAST = CELL_H - 6'd1;
  localparam logic [3:0] SD_RST = 4'b1100;
  localparam logic [2:0] PAL [8] = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b101, 3'b111};
  logic [9:0] hcnt, vcnt;
  logic [6:0] hsub;
  logic [5:0] vsub;
  logic [3:0] cx, cy;
  logic [3:0] sd1, sd2;
  logic       act1, act2, bd1, bd2;
  logic       hend, vend, active, hwrap, vwrap, bd0;
  logic [3:0] sd0;
  always_comb begin
    hend   = hcnt == H_LAST;
    vend   = vcnt == V_LAST;
    hwrap  = hsub == HSUB_LAST;
    vwrap  = vsub == VSUB_LAST;
    active = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE);
    sd0    = {!(hcnt >= HS_LO && hcnt < HS_HI), !(vcnt >= VS_LO && vcnt < VS_HI),
              vcnt >= V_ACTIVE, hcnt == 10'd0 && vcnt == 10'd0};
`ifdef CURSOR_OVERLAY_EN
    bd0    = ({4'd0, cx} == curX) && ({4'd0, cy} == curY) && (curX < {4'd0, GRID_N}) &&
             (hsub == 7'd0 || hwrap || vsub == 6'd0 || vwrap);
`else
    bd0    = 1'b0;
`endif
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
      hsub <= '0;
      vsub <= '0;
      cx   <= '0;
      cy   <= '0;
    end else begin
      hcnt <= hend ? '0 : hcnt + 10'd1;
      hsub <= (hend || hwrap) ? '0 : hsub + 7'd1;
      cx   <= hend ? '0 : cx + {3'd0, hwrap};
      if (hend) begin
        vcnt <= vend ? '0 : vcnt + 10'd1;
        vsub <= (vend || vwrap) ? '0 : vsub + 6'd1;
        cy   <= vend ? '0 : cy + {3'd0, vwrap};
      end
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx  <= '0;
      ry  <= '0;
      sd1 <= SD_RST;
      sd2 <= SD_RST;
      {hsync, vsync, vblank, frameStart} <= SD_RST;
      act1 <= 1'b0;
      act2 <= 1'b0;
      bd1  <= 1'b0;
      bd2  <= 1'b0;
      {r, g, b} <= '0;
    end else begin
      rx  <= (active && cx < GRID_N) ? {4'd0, cx} : '0;
      ry  <= (vcnt < V_ACTIVE) ? {4'd0, cy} : '0;
      sd1 <= sd0;
      sd2 <= sd1;
      {hsync, vsync, vblank, frameStart} <= sd2;
      act1 <= active;
      act2 <= act1;
      bd1  <= bd0;
      bd2  <= bd1;
      {r, g, b} <= (PAL[colorCode] ^ {3{bd2}}) & {3{act2}};
    end
endmodule
